// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage of the single-cycle MIPS core. It owns the PC,
// fetches one word at a time from instruction memory over a req/ack
// handshake and holds that word for the execute window. The opcode field
// goes to the control decoder. At the end of the window the unit picks the
// next PC from the decoder's Jump/BEQ/BNE outputs and the ALU zero flag,
// then counts the instruction as retired.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (current PC)
//   imem_ack/imem_rdata memory response strobe and instruction word
//   stall               datapath hold; extends the execute window
//   Jump, BEQ, BNE      control decoder outputs
//   zero                ALU zero flag
//   instr, opcode       held instruction word and its bits [31:26]
//   instr_valid         high while instr is being executed
//   pc, pc_plus4        PC of the held instruction and PC+4
//   retire              one-cycle pulse after an instruction commits
//   instr_count         retired-instruction counter (wraps)
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              Jump,
  input  logic              BEQ,
  input  logic              BNE,
  input  logic              zero,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              retire,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] next_pc;
  logic              commit;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc + ADDR_W'(4);

  // The branch offset is a signed word count, so it is sign-extended and
  // scaled to bytes. The jump target keeps the top nibble of PC+4.
  assign branch_target = pc_plus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[ADDR_W-1:ADDR_W-4], instr[25:0], 2'b00};

  // An instruction commits on the last EXEC cycle, which is the first one
  // without a stall.
  assign commit = (state == EXEC) && !stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake outputs. imem_req is decoded from the
  // state, so an asynchronous reset drops it immediately. An ack outside
  // FETCH has no effect on the next state.
  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          next_state = FETCH == FETCH ? EXEC : EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          next_state = FETCH;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Next-PC selection. Jump takes priority over both branches. When BEQ
  // and BNE are both set, exactly one of them is taken, depending on zero.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (BEQ && zero) begin
      next_pc = branch_target;
    end else if (BNE && !zero) begin
      next_pc = branch_target;
    end
  end

  // Datapath registers. The instruction is captured only on an ack in
  // FETCH. The PC, retire pulse and counter update when an instruction
  // commits. The two low PC bits are cleared on every load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      retire      <= 1'b0;
      instr_count <= '0;
    end else begin
      retire <= commit;
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (commit) begin
        pc          <= {next_pc[ADDR_W-1:2], 2'b00};
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule
